// File: rtl/rtc_cal_if.sv
`timescale 1ns/1ps
// rtc_cal_if: command strobe, serial shift port and status outputs of the
// real-time calendar. The controller drives through master; rtc_cal uses slave.
interface rtc_cal_if;
  logic       cstb;
  logic       cclk;
  logic [3:0] cin;
  logic       cdata;
  logic       ind;
  logic       tp;
  logic       irq;

  modport master (output cstb, cclk, cin, input cdata, ind, tp, irq);
  modport slave  (input cstb, cclk, cin, output cdata, ind, tp, irq);
endinterface

// File: rtl/rtc_cal.sv
`timescale 1ns/1ps
// rtc_cal: BCD real-time calendar with a serial command/shift port.
// A prescaler divides clk down to one tick per second; the tick walks the
// sec/min/hour/day/month(/year) cascade. cin=1 latches the time into the
// shift register, cin=2 loads the time back from it, cclk shifts it right.
// Optional alarm: define RTC_ALARM_EN to get the cin=3 alarm load and irq.
module rtc_cal #(
  parameter int CLK_HZ    = 14318182,
  parameter int WITH_YEAR = 1
) (
  input logic      clk,
  input logic      rst_n,
  rtc_cal_if.slave bus
);
  localparam int            PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int            SW    = (WITH_YEAR != 0) ? 48 : 40;
  localparam logic [PW-1:0] PMAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PHALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0]    day_q, day_d, year_q, year_d;
  logic [3:0]    mon_q, mon_d, wday_q, wday_d;
  logic [SW-1:0] sr_q, sr_d;
  logic          cstbPrev_q, cclkPrev_q;

  logic          strobe, shiftEdge, doLatch, doLoad, tick, leap;
  logic          secWrap, minWrap, hourWrap, dayWrap, monWrap;
  logic [7:0]    dayMax, secNext, minNext, hourNext, dayNext, yearNext;
  logic [47:0]   srExt, snap48;

  // Next BCD value: at/above the maximum (including illegal codes) wraps to
  // the minimum, otherwise a decimal increment of the two digits.
  function automatic logic [7:0] bcdNext(input logic [7:0] v,
                                         input logic [7:0] maxV,
                                         input logic [7:0] minV);
    logic [7:0] r;
    if (v >= maxV)            r = minV;
    else if (v[3:0] >= 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign strobe    = bus.cstb & ~cstbPrev_q;
  assign shiftEdge = bus.cclk & ~cclkPrev_q;
  assign doLatch   = strobe && (bus.cin == 4'd1);
  assign doLoad    = strobe && (bus.cin == 4'd2);
  assign tick      = (presc_q == PMAX);

  assign srExt  = 48'(sr_q);
  assign snap48 = {((WITH_YEAR != 0) ? year_q : 8'h00), mon_q,
                   1'b0, wday_q[2:0], 2'b00, day_q[5:0], 2'b00, hour_q[5:0],
                   1'b0, min_q[6:0], 1'b0, sec_q[6:0]};

  // Leap-year test on the BCD digits and the month-dependent last day.
  always_comb begin
    leap = 1'b0;
    if (WITH_YEAR != 0) begin
      if (!year_q[4]) leap = (year_q[3:0] == 4'd0) || (year_q[3:0] == 4'd4) || (year_q[3:0] == 4'd8);
      else            leap = (year_q[3:0] == 4'd2) || (year_q[3:0] == 4'd6);
    end
    case (mon_q)
      4'd4, 4'd6, 4'd9, 4'd11: dayMax = 8'h30;
      4'd2:                    dayMax = leap ? 8'h29 : 8'h28;
      default:                 dayMax = 8'h31;
    endcase
  end

  assign secNext  = bcdNext(sec_q,  8'h59, 8'h00);
  assign minNext  = bcdNext(min_q,  8'h59, 8'h00);
  assign hourNext = bcdNext(hour_q, 8'h23, 8'h00);
  assign dayNext  = bcdNext(day_q,  dayMax, 8'h01);
  assign yearNext = bcdNext(year_q, 8'h99, 8'h00);
  assign secWrap  = (sec_q  >= 8'h59);
  assign minWrap  = (min_q  >= 8'h59);
  assign hourWrap = (hour_q >= 8'h23);
  assign dayWrap  = (day_q  >= dayMax);
  assign monWrap  = (mon_q  >= 4'd12);

  // Prescaler and time fields: a load wins over the tick in the same cycle.
  always_comb begin
    presc_d = presc_q + PW'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    wday_d  = wday_q;
    mon_d   = mon_q;
    year_d  = year_q;
    if (doLoad) begin
      presc_d = '0;
      sec_d   = srExt[7:0];
      min_d   = srExt[15:8];
      hour_d  = srExt[23:16];
      day_d   = srExt[31:24];
      wday_d  = srExt[35:32];
      mon_d   = srExt[39:36];
      if (WITH_YEAR != 0) year_d = srExt[47:40];
    end else if (tick) begin
      presc_d = '0;
      sec_d   = secNext;
      if (secWrap) begin
        min_d = minNext;
        if (minWrap) begin
          hour_d = hourNext;
          if (hourWrap) begin
            day_d  = dayNext;
            wday_d = (wday_q >= 4'd6) ? 4'd0 : wday_q + 4'd1;
            if (dayWrap) begin
              mon_d = monWrap ? 4'd1 : mon_q + 4'd1;
              if (monWrap && (WITH_YEAR != 0)) year_d = yearNext;
            end
          end
        end
      end
    end
  end

  // Shift register: latching a snapshot takes priority over a shift.
  always_comb begin
    sr_d = sr_q;
    if (doLatch)        sr_d = snap48[SW-1:0];
    else if (shiftEdge) sr_d = {bus.cin[0], sr_q[SW-1:1]};
  end

  // State registers for the time, prescaler, shift register and edge samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      day_q      <= 8'h01;
      wday_q     <= 4'd0;
      mon_q      <= 4'd1;
      year_q     <= 8'h00;
      sr_q       <= '0;
      cstbPrev_q <= 1'b0;
      cclkPrev_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      wday_q     <= wday_d;
      mon_q      <= mon_d;
      year_q     <= year_d;
      sr_q       <= sr_d;
      cstbPrev_q <= bus.cstb;
      cclkPrev_q <= bus.cclk;
    end
  end

  assign bus.cdata = sr_q[0];
  assign bus.ind   = (presc_q < PHALF);
  assign bus.tp    = tick & ~doLoad;

`ifdef RTC_ALARM_EN
  logic [23:0] alarm_q, alarm_d;
  logic        irq_q, irq_d;

  // Alarm load on cin=3; irq set by a matching tick, cleared by a latch.
  always_comb begin
    alarm_d = alarm_q;
    irq_d   = irq_q;
    if (strobe && (bus.cin == 4'd3)) alarm_d = sr_q[23:0];
    if (doLatch) irq_d = 1'b0;
    if (tick && !doLoad && ({hour_d, min_d, sec_d} == alarm_q)) irq_d = 1'b1;
  end

  // Alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 24'h000000;
      irq_q   <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_cal.sv
`timescale 1ns/1ps
// tb_rtc_cal: directed and randomized checks of rtc_cal at CLK_HZ=10 against
// a calendar model that counts plain integer seconds/minutes/days.
module tb_rtc_cal;
  localparam int CLK_HZ = 10;

  logic clk = 1'b0;
  logic rst_n;
  rtc_cal_if bus();

  rtc_cal #(.CLK_HZ(CLK_HZ), .WITH_YEAR(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int mYear, mMon, mDay, mWday, mHour, mMin, mSec;

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int daysIn(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] toBcd(input int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic logic [47:0] packModel();
    logic [3:0] m4, w4;
    m4 = 4'(mMon);
    w4 = 4'(mWday);
    return {toBcd(mYear), m4, w4, toBcd(mDay), toBcd(mHour), toBcd(mMin), toBcd(mSec)};
  endfunction

  // One second of calendar time, in ordinary integer arithmetic.
  function automatic void modelTick();
    mSec++;
    if (mSec == 60) begin
      mSec = 0; mMin++;
      if (mMin == 60) begin
        mMin = 0; mHour++;
        if (mHour == 24) begin
          mHour = 0;
          mWday = (mWday + 1) % 7;
          mDay++;
          if (mDay > daysIn(mMon, mYear)) begin
            mDay = 1; mMon++;
            if (mMon > 12) begin
              mMon = 1;
              mYear = (mYear + 1) % 100;
            end
          end
        end
      end
    end
  endfunction

  // Strobe pulse with a trailing low cycle; starts and ends just after a negedge.
  task automatic strobe(input logic [3:0] code);
    bus.cin  = code;
    bus.cstb = 1'b1;
    @(negedge clk);
    bus.cstb = 1'b0;
    bus.cin  = 4'd0;
    @(negedge clk);
  endtask

  task automatic shiftBit(input logic b);
    bus.cin  = {3'b000, b};
    bus.cclk = 1'b1;
    @(negedge clk);
    bus.cclk = 1'b0;
    bus.cin  = 4'd0;
    @(negedge clk);
  endtask

  task automatic shiftWord(input logic [47:0] w);
    for (int i = 0; i < 48; i++) shiftBit(w[i]);
  endtask

  task automatic readWord(output logic [47:0] w);
    for (int i = 0; i < 48; i++) begin
      w[i] = bus.cdata;
      shiftBit(1'b0);
    end
  endtask

  // Shift a full time word in and load it.
  task automatic applyStimulus(input logic [47:0] w);
    shiftWord(w);
    strobe(4'd2);
  endtask

  // Wait until n ticks have happened since the load, counting tp pulses.
  task automatic waitSeconds(input int n, output int tpSeen);
    tpSeen = 0;
    repeat (CLK_HZ * n - 1) begin
      if (bus.tp) tpSeen++;
      @(negedge clk);
    end
  endtask

  task automatic runCase(input string tag, input int y, input int mo, input int d,
                         input int w, input int h, input int mi, input int s, input int n);
    logic [47:0] got;
    int          tpSeen;
    mYear = y; mMon = mo; mDay = d; mWday = w; mHour = h; mMin = mi; mSec = s;
    applyStimulus(packModel());
    waitSeconds(n, tpSeen);
    strobe(4'd1);
    readWord(got);
    for (int i = 0; i < n; i++) modelTick();
    checkOutput(tag, got, packModel());
    checkOutput({tag, " tp count"}, 48'(tpSeen), 48'(n));
  endtask

  initial begin
    logic [47:0] got;
    int          found;

    rst_n = 1'b0; bus.cstb = 1'b0; bus.cclk = 1'b0; bus.cin = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset ind", 48'(bus.ind), 48'd1);
    checkOutput("reset tp", 48'(bus.tp), 48'd0);
    checkOutput("reset cdata", 48'(bus.cdata), 48'd0);
    checkOutput("reset irq", 48'(bus.irq), 48'd0);

    rst_n = 1'b1;
    strobe(4'd1);
    readWord(got);
    checkOutput("reset time", got, {8'h00, 4'h1, 4'h0, 8'h01, 24'h000000});

    applyStimulus({8'h07, 4'h5, 4'h3, 8'h20, 8'h12, 8'h34, 8'h56});
    strobe(4'd1);
    readWord(got);
    checkOutput("serial 12:34:56", 48'(got[23:0]), 48'h123456);
    readWord(got);
    checkOutput("register drained", got, 48'h0);

    runCase("century rollover", 99, 12, 31, 6, 23, 59, 59, 1);
    runCase("leap 24 feb28", 24, 2, 28, 1, 23, 59, 59, 1);
    runCase("plain 23 feb28", 23, 2, 28, 2, 23, 59, 59, 1);
    runCase("leap 00 feb29", 0, 2, 29, 3, 23, 59, 59, 1);
    runCase("apr30", 21, 4, 30, 4, 23, 59, 59, 1);

    applyStimulus({8'h24, 4'h3, 4'h2, 8'h15, 8'h05, 8'h10, 8'h7A});
    waitSeconds(1, found);
    strobe(4'd1);
    readWord(got);
    checkOutput("illegal sec 7A", got, {8'h24, 4'h3, 4'h2, 8'h15, 8'h05, 8'h11, 8'h00});

    for (int k = 0; k < 6; k++) begin
      int y, mo;
      y  = int'($urandom_range(0, 99));
      mo = int'($urandom_range(1, 12));
      runCase($sformatf("random %0d", k), y, mo, daysIn(mo, y) - int'($urandom_range(0, 1)),
              int'($urandom_range(0, 6)), 23, 59, int'($urandom_range(50, 59)),
              int'($urandom_range(1, 12)));
    end

    // Reset in the middle of a shift sequence and of a prescaler period.
    shiftWord(48'hFFFF_FFFF_FFFF);
    for (int i = 0; i < 20; i++) shiftBit(1'b1);
    checkOutput("cdata before reset", 48'(bus.cdata), 48'd1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.ind == 1'b0) found = 1;
    end
    checkOutput("ind low before reset", 48'(found), 48'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset ind", 48'(bus.ind), 48'd1);
    checkOutput("async reset tp", 48'(bus.tp), 48'd0);
    checkOutput("async reset cdata", 48'(bus.cdata), 48'd0);
    checkOutput("async reset irq", 48'(bus.irq), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    shiftBit(1'b1);
    checkOutput("first shift after reset", 48'(bus.cdata), 48'd0);
    for (int i = 0; i < 47; i++) shiftBit(1'b0);
    checkOutput("marker bit arrives", 48'(bus.cdata), 48'd1);

`ifdef RTC_ALARM_EN
    shiftWord(48'h000000_000005);
    strobe(4'd3);
    applyStimulus({8'h00, 4'h1, 4'h0, 8'h01, 24'h000000});
    strobe(4'd1);
    repeat (46) @(negedge clk);
    checkOutput("irq before 5th tick", 48'(bus.irq), 48'd0);
    @(negedge clk);
    checkOutput("irq at 5th tick", 48'(bus.irq), 48'd1);
    strobe(4'd1);
    checkOutput("irq cleared by latch", 48'(bus.irq), 48'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/rtc_cal.md
RTC_CAL -- requirements
Module: rtc_cal

Interface
REQ-001 SHALL have parameter CLK_HZ, default 14318182, clk cycles per second.
REQ-002 SHALL have parameter WITH_YEAR, default 1: 1 adds BCD year field 00-99 and leap-year logic; 0 omits it.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cstb  input  1  command strobe, acted on at rising edge.
REQ-006 SHALL have port cclk  input  1  shift clock, acted on at rising edge.
REQ-007 SHALL have port cin  input  4  command code at strobe edge; cin[0] is serial data-in at shift edge.
REQ-008 SHALL have port cdata  output  1  serial data-out, equals shift-register bit 0.
REQ-009 SHALL have port ind  output  1  high while prescaler < CLK_HZ/2.
REQ-010 SHALL have port tp  output  1  one-cycle pulse on each second tick.
REQ-011 SHALL have port irq  output  1  alarm flag (see Configuration).

Function
REQ-012 SHALL count prescaler 0..CLK_HZ-1; tick when it equals CLK_HZ-1, then wrap to 0.
REQ-013 SHALL keep BCD seconds 00-59, minutes 00-59, hours 00-23, day 01-31, binary month 1-12, weekday 0-6, BCD year 00-99 (WITH_YEAR=1).
REQ-014 SHALL cascade on tick: sec->min->hour->day->month->year, with weekday incrementing (6->0) on every day carry.
REQ-015 SHALL end months: 4/6/9/11 after 30; 2 after 29 if leap, else 28; others after 31; day then returns to 01.
REQ-016 SHALL treat year as leap when (tens even and units in 0,4,8) or (tens odd and units in 2,6); with WITH_YEAR=0 February always ends after 28.
REQ-017 SHALL, for any field at or above its maximum (including illegal loaded values) when its carry-in arrives, set it to its minimum and carry out.
REQ-018 SHALL detect strobe/shift edges as input high while previous-cycle sample low; one action per edge.
REQ-019 SHALL on cstb edge with cin=1 latch time into shift register: [7:0] sec, [15:8] min, [23:16] hour, [31:24] day, [35:32] weekday, [39:36] month, [47:40] year (WITH_YEAR=1); unused BCD tens bits zero.
REQ-020 SHALL on cstb edge with cin=2 load all fields from the same layout and clear the prescaler in that cycle.
REQ-021 SHALL treat cin=0 and other undefined codes as no-op.
REQ-022 SHALL on cclk edge shift register right one bit, MSB (bit 39 or 47) taking cin[0].
REQ-023 SHALL give priority on coincident events: load over tick (no increment that cycle), latch over shift.
REQ-024 SHALL pulse tp in the cycle the tick occurs.

Reset
REQ-025 SHALL, while rst_n low, set prescaler 0, sec/min/hour 00, day 01, month 1, weekday 0, year 00, shift register 0, edge samples 0, alarm 00:00:00, irq 0, tp 0; ind reads 1.
REQ-026 SHALL abandon any partial shift on reset; first shift edge after release uses cleared register.

Configuration
REQ-027 SHALL with RTC_ALARM_EN defined, on cstb edge with cin=3, load alarm hour/min/sec from shift-register [23:0].
REQ-028 SHALL with RTC_ALARM_EN defined, set irq on a tick whose resulting time equals the alarm, and clear irq on a cin=1 strobe (set wins if coincident).
REQ-029 SHALL without RTC_ALARM_EN, tie irq to 0, treat cin=3 as no-op, and have no alarm registers.

Verification (CLK_HZ=10, WITH_YEAR=1)
REQ-030 SHALL cover: load 99 Dec 31 weekday 6 23:59:59, 10 clks -> year 00 Jan 01 weekday 0 00:00:00, tp one pulse.
REQ-031 SHALL cover: year 24 Feb 28 23:59:59 + tick -> Feb 29; year 23 same -> Mar 01; year 00 Feb 29 23:59:59 + tick -> Mar 01.
REQ-032 SHALL cover: Apr 30 23:59:59 + tick -> May 01; loaded sec 0x7A + 1 min-carry path -> sec 00, min +1.
REQ-033 SHALL cover: latch 12:34:56, 48 cclk edges with cin[0]=0 -> cdata serial 0x56,0x34,0x12 LSB first, register then zero.
REQ-034 SHALL cover (RTC_ALARM_EN): alarm 00:00:05 from 00:00:00 -> irq rises at 5th tick, cleared by cin=1 strobe.
REQ-035 SHALL cover: rst_n low after 20 shift edges and mid-prescaler -> all REQ-025 values immediately, cdata 0.
